// File: rtl/incr_chain_pkg.sv
// Shared constants and types for the incrementing pipeline.
package incr_chain_pkg;

  // Legal parameter ranges for incr_chain.
  localparam int WIDTH_MIN  = 1;
  localparam int WIDTH_MAX  = 64;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 16;

  // Delivered-result counter width; it wraps silently.
  localparam int COUNT_W = 16;

  typedef logic [COUNT_W-1:0] count_t;

  // Reduce a 64-bit step constant modulo 2^width.
  function automatic logic [63:0] reduceStep(input logic [63:0] step, input int width);
    if (width >= 64) begin
      return step;
    end
    return step & ((64'd1 << width) - 64'd1);
  endfunction

endpackage

// File: rtl/incr_chain_if.sv
// Producer/consumer bus for incr_chain: input handshake, output handshake,
// flush and the delivered-result counter.
interface incr_chain_if #(
  parameter int WIDTH = 32
);
  import incr_chain_pkg::*;

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_wrap;
  count_t           out_count;

  // Side that feeds operands and consumes results.
  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_wrap, out_count
  );

  // The pipeline itself.
  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_wrap, out_count
  );

endinterface

// File: rtl/incr_stage.sv
// One pipeline stage: registers (previous data + STEP), merges the carry-out
// into the sticky wrap flag, and accepts whenever it is empty or its own
// entry is leaving this cycle, so bubbles collapse.
module incr_stage #(
  parameter int          WIDTH = 32,
  parameter logic [63:0] STEP  = 64'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_wrap,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_wrap
);
  import incr_chain_pkg::*;

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(reduceStep(STEP, WIDTH));

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_wrap;
  logic [WIDTH:0]   w_sum;
  logic             w_accept;
  logic             w_load;

  assign w_sum    = {1'b0, i_data} + {1'b0, STEP_W};
  assign w_accept = !r_valid || i_ready;
  assign w_load   = i_valid && w_accept;

  // Stage register: flush only empties the stage, data/wrap follow loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_wrap  <= 1'b0;
    end else begin
      if (i_flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid <= i_valid;
      end
      if (w_load) begin
        r_data <= w_sum[WIDTH-1:0];
        r_wrap <= i_wrap | w_sum[WIDTH];
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_wrap  = r_wrap;

endmodule

// File: rtl/incr_chain.sv
// Elastic chain of STAGES registered incrementers. Each result equals
// in_data + STAGES*STEP (mod 2^WIDTH) with a flag if any stage overflowed.
module incr_chain #(
  parameter int          WIDTH  = 32,
  parameter int          STAGES = 4,
  parameter logic [63:0] STEP   = 64'd1
) (
  input logic         clk,
  input logic         rst,
  incr_chain_if.slave bus
);
  import incr_chain_pkg::*;

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
      STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_paramCheck
    $error("incr_chain: WIDTH or STAGES outside the supported range");
  end

  logic [STAGES:0]  w_valid;
  logic [STAGES:0]  w_wrap;
  logic [STAGES:0]  w_ready;
  logic [WIDTH-1:0] w_data [STAGES+1];
  logic             w_deliver;
  count_t           r_count;

  // Slot 0 is the input port; a flush cycle ignores any offered operand.
  assign w_valid[0] = bus.in_valid && !bus.flush;
  assign w_data[0]  = bus.in_data;
  assign w_wrap[0]  = 1'b0;

  // Ready ripples back from the consumer: a stage can take a new entry
  // when it is empty or the stage after it takes its current one.
  always_comb begin
    w_ready         = '0;
    w_ready[STAGES] = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_ready[k] = !w_valid[k+1] || w_ready[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    incr_stage #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_flush (bus.flush),
      .i_valid (w_valid[k]),
      .i_data  (w_data[k]),
      .i_wrap  (w_wrap[k]),
      .i_ready (w_ready[k+1]),
      .o_valid (w_valid[k+1]),
      .o_data  (w_data[k+1]),
      .o_wrap  (w_wrap[k+1])
    );
  end

  // Outputs read as zero while reset is held.
  assign bus.in_ready  = !rst && !bus.flush && w_ready[0];
  assign bus.out_valid = !rst && w_valid[STAGES];
  assign bus.out_data  = rst ? '0 : w_data[STAGES];
  assign bus.out_wrap  = !rst && w_wrap[STAGES];
  assign bus.out_count = r_count;

  assign w_deliver = w_valid[STAGES] && bus.out_ready;

  // Count delivered results; a flush in the same cycle still counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_deliver) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_incr_chain.sv
// Directed bench for incr_chain: three configurations (32-bit default,
// 8-bit for wrap behaviour, 16-bit with a step that reduces to zero).
module tb_incr_chain;
  import incr_chain_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  incr_chain_if #(.WIDTH(32)) busA ();
  incr_chain_if #(.WIDTH(8))  busB ();
  incr_chain_if #(.WIDTH(16)) busC ();

  incr_chain #(.WIDTH(32), .STAGES(4), .STEP(64'd1))     dutA (.clk(clk), .rst(rst), .bus(busA));
  incr_chain #(.WIDTH(8),  .STAGES(4), .STEP(64'd1))     dutB (.clk(clk), .rst(rst), .bus(busB));
  incr_chain #(.WIDTH(16), .STAGES(2), .STEP(64'h10000)) dutC (.clk(clk), .rst(rst), .bus(busC));

  typedef struct {
    string       name;
    int          unit;
    logic [31:0] din;
    logic [31:0] dout;
    logic        wrap;
    int          latency;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(input string n, input int u, input logic [31:0] di,
                                 input logic [31:0] dq, input logic w, input int lat);
    vec_t v;
    v.name = n; v.unit = u; v.din = di; v.dout = dq; v.wrap = w; v.latency = lat;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic getValid(input int unit);
    case (unit)
      0:       return busA.out_valid;
      1:       return busB.out_valid;
      default: return busC.out_valid;
    endcase
  endfunction

  function automatic logic getReady(input int unit);
    case (unit)
      0:       return busA.in_ready;
      1:       return busB.in_ready;
      default: return busC.in_ready;
    endcase
  endfunction

  function automatic logic [31:0] getData(input int unit);
    case (unit)
      0:       return busA.out_data;
      1:       return {24'd0, busB.out_data};
      default: return {16'd0, busC.out_data};
    endcase
  endfunction

  function automatic logic getWrap(input int unit);
    case (unit)
      0:       return busA.out_wrap;
      1:       return busB.out_wrap;
      default: return busC.out_wrap;
    endcase
  endfunction

  function automatic count_t getCount(input int unit);
    case (unit)
      0:       return busA.out_count;
      1:       return busB.out_count;
      default: return busC.out_count;
    endcase
  endfunction

  task automatic applyStimulus(input int unit, input logic v, input logic [31:0] d, input logic ordy);
    case (unit)
      0: begin busA.in_valid = v; busA.in_data = d;        busA.out_ready = ordy; end
      1: begin busB.in_valid = v; busB.in_data = d[7:0];   busB.out_ready = ordy; end
      default: begin busC.in_valid = v; busC.in_data = d[15:0]; busC.out_ready = ordy; end
    endcase
  endtask

  // Single beat through an idle pipe with the consumer always ready.
  task automatic runVector(input vec_t v);
    int     waits;
    int     lat;
    count_t cnt0;
    cnt0 = getCount(v.unit);
    applyStimulus(v.unit, 1'b1, v.din, 1'b1);
    #1;
    waits = 0;
    while (!getReady(v.unit) && waits < 20) begin
      tick();
      waits++;
    end
    checkOutput({v.name, " accept"}, 64'(getReady(v.unit)), 64'd1);
    tick();
    applyStimulus(v.unit, 1'b0, 32'd0, 1'b1);
    lat = 1;
    while (!getValid(v.unit) && lat < 20) begin
      tick();
      lat++;
    end
    checkOutput({v.name, " latency"}, 64'(lat), 64'(v.latency));
    checkOutput({v.name, " data"}, 64'(getData(v.unit)), 64'(v.dout));
    checkOutput({v.name, " wrap"}, 64'(getWrap(v.unit)), 64'(v.wrap));
    tick();
    checkOutput({v.name, " count"}, 64'(getCount(v.unit)), 64'(count_t'(cnt0 + 1'b1)));
  endtask

  task automatic streamTest;
    int     sent = 0;
    int     recv = 0;
    int     cyc = 0;
    int     firstCyc = -1;
    int     lastCyc = -1;
    logic   acc;
    count_t cnt0;
    cnt0 = busA.out_count;
    busA.out_ready = 1'b1;
    while (recv < 100 && cyc < 300) begin
      busA.in_valid = (sent < 100);
      busA.in_data  = 32'(sent);
      #1;
      acc = busA.in_valid && busA.in_ready;
      if (busA.out_valid) begin
        checkOutput("stream data", 64'(busA.out_data), 64'(recv + 4));
        if (firstCyc < 0) firstCyc = cyc;
        lastCyc = cyc;
        recv++;
      end
      tick();
      cyc++;
      if (acc) sent++;
    end
    busA.in_valid = 1'b0;
    checkOutput("stream received", 64'(recv), 64'd100);
    checkOutput("stream first latency", 64'(firstCyc), 64'd4);
    checkOutput("stream no bubbles", 64'(lastCyc - firstCyc + 1), 64'd100);
    checkOutput("stream count", 64'(busA.out_count), 64'(count_t'(cnt0 + 16'd100)));
  endtask

  task automatic stallTest;
    int          accepted = 0;
    int          recv = 0;
    logic        acc;
    logic        heldSeen = 1'b0;
    logic        stable = 1'b1;
    logic [31:0] held = '0;
    count_t      cnt0;
    cnt0 = busA.out_count;
    busA.out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      busA.in_valid = 1'b1;
      busA.in_data  = 32'd200 + 32'(accepted);
      #1;
      if (busA.out_valid) begin
        if (!heldSeen) begin
          held = busA.out_data;
          heldSeen = 1'b1;
        end else if (busA.out_data !== held || busA.out_wrap !== 1'b0) begin
          stable = 1'b0;
        end
      end
      acc = busA.in_valid && busA.in_ready;
      tick();
      if (acc) accepted++;
    end
    busA.in_valid = 1'b0;
    #1;
    checkOutput("stall accepted", 64'(accepted), 64'd4);
    checkOutput("stall in_ready low", 64'(busA.in_ready), 64'd0);
    checkOutput("stall out_valid held", 64'(busA.out_valid), 64'd1);
    checkOutput("stall output stable", 64'(stable), 64'd1);
    checkOutput("stall head data", 64'(held), 64'd204);
    busA.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (busA.out_valid) begin
        checkOutput("stall drain data", 64'(busA.out_data), 64'(204 + recv));
        recv++;
      end
      tick();
      #1;
    end
    checkOutput("stall drained", 64'(recv), 64'd4);
    checkOutput("stall count", 64'(busA.out_count), 64'(count_t'(cnt0 + 16'd4)));
  endtask

  task automatic flushTest;
    int     delivered = 0;
    count_t cnt0;
    cnt0 = busA.out_count;
    busA.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      busA.in_valid = 1'b1;
      busA.in_data  = 32'd300 + 32'(c);
      #1;
      checkOutput("flush fill ready", 64'(busA.in_ready), 64'd1);
      tick();
    end
    busA.flush    = 1'b1;
    busA.in_valid = 1'b1;
    busA.in_data  = 32'd999;
    #1;
    checkOutput("flush in_ready low", 64'(busA.in_ready), 64'd0);
    tick();
    busA.flush     = 1'b0;
    busA.in_valid  = 1'b0;
    busA.out_ready = 1'b1;
    #1;
    checkOutput("flush out_valid", 64'(busA.out_valid), 64'd0);
    checkOutput("flush in_ready next", 64'(busA.in_ready), 64'd1);
    for (int c = 0; c < 8; c++) begin
      if (busA.out_valid) delivered++;
      tick();
    end
    checkOutput("flush none delivered", 64'(delivered), 64'd0);
    checkOutput("flush count", 64'(busA.out_count), 64'(cnt0));
  endtask

  task automatic flushDeliverTest;
    int     waits = 0;
    count_t cnt0;
    cnt0 = busA.out_count;
    busA.out_ready = 1'b0;
    busA.in_valid  = 1'b1;
    busA.in_data   = 32'd50;
    #1;
    tick();
    busA.in_valid = 1'b0;
    while (!busA.out_valid && waits < 20) begin
      tick();
      waits++;
    end
    checkOutput("flushdel valid", 64'(busA.out_valid), 64'd1);
    checkOutput("flushdel data", 64'(busA.out_data), 64'd54);
    busA.flush     = 1'b1;
    busA.out_ready = 1'b1;
    tick();
    busA.flush = 1'b0;
    #1;
    checkOutput("flushdel count", 64'(busA.out_count), 64'(count_t'(cnt0 + 1'b1)));
    checkOutput("flushdel out_valid", 64'(busA.out_valid), 64'd0);
  endtask

  task automatic resetMidTest;
    busA.out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      busA.in_valid = 1'b1;
      busA.in_data  = 32'd400 + 32'(c);
      tick();
    end
    checkOutput("rstmid pre valid", 64'(busA.out_valid), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("rstmid out_valid", 64'(busA.out_valid), 64'd0);
    checkOutput("rstmid out_data", 64'(busA.out_data), 64'd0);
    checkOutput("rstmid out_wrap", 64'(busA.out_wrap), 64'd0);
    checkOutput("rstmid in_ready", 64'(busA.in_ready), 64'd0);
    tick();
    checkOutput("rstmid count", 64'(busA.out_count), 64'd0);
    checkOutput("rstmid out_valid edge", 64'(busA.out_valid), 64'd0);
    rst = 1'b0;
    busA.in_valid = 1'b0;
    #1;
    checkOutput("rstmid in_ready after", 64'(busA.in_ready), 64'd1);
    runVector(mkVec("A after rst 7", 0, 32'd7, 32'd11, 1'b0, 4));
    checkOutput("rstmid count after", 64'(busA.out_count), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    busA.flush = 1'b0; busB.flush = 1'b0; busC.flush = 1'b0;
    applyStimulus(0, 1'b0, 32'd0, 1'b0);
    applyStimulus(1, 1'b0, 32'd0, 1'b0);
    applyStimulus(2, 1'b0, 32'd0, 1'b0);

    vecs.push_back(mkVec("A 0x1111",     0, 32'h0000_1111, 32'h0000_1115, 1'b0, 4));
    vecs.push_back(mkVec("A 0xFFFFFFFE", 0, 32'hFFFF_FFFE, 32'h0000_0002, 1'b1, 4));
    vecs.push_back(mkVec("A 0xFFFFFFFB", 0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0, 4));
    vecs.push_back(mkVec("A 0xFFFFFFFC", 0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 4));
    vecs.push_back(mkVec("B 0xFE",       1, 32'h0000_00FE, 32'h0000_0002, 1'b1, 4));
    vecs.push_back(mkVec("B 0xFB",       1, 32'h0000_00FB, 32'h0000_00FF, 1'b0, 4));
    vecs.push_back(mkVec("B 0xFC",       1, 32'h0000_00FC, 32'h0000_0000, 1'b1, 4));
    vecs.push_back(mkVec("B 0x7F",       1, 32'h0000_007F, 32'h0000_0083, 1'b0, 4));
    vecs.push_back(mkVec("B 0x00",       1, 32'h0000_0000, 32'h0000_0004, 1'b0, 4));
    vecs.push_back(mkVec("C 0x1234",     2, 32'h0000_1234, 32'h0000_1234, 1'b0, 2));
    vecs.push_back(mkVec("C 0xFFFF",     2, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 2));
    vecs.push_back(mkVec("C 0x0000",     2, 32'h0000_0000, 32'h0000_0000, 1'b0, 2));

    #1;
    checkOutput("reset out_valid", 64'(busA.out_valid), 64'd0);
    checkOutput("reset in_ready", 64'(busA.in_ready), 64'd0);
    checkOutput("reset out_data", 64'(busA.out_data), 64'd0);
    tick();
    tick();
    checkOutput("reset count", 64'(busA.out_count), 64'd0);
    checkOutput("reset count B", 64'(busB.out_count), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("first ready after rst", 64'(busA.in_ready), 64'd1);
    checkOutput("idle out_valid", 64'(busA.out_valid), 64'd0);

    $display("[TB] directed vectors");
    foreach (vecs[i]) runVector(vecs[i]);

    $display("[TB] streaming");
    streamTest();
    $display("[TB] stall and release");
    stallTest();
    $display("[TB] flush");
    flushTest();
    flushDeliverTest();
    $display("[TB] reset mid-stream");
    resetMidTest();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] time limit reached");
  end

endmodule
